// File: rtl/byang_prereduce.sv
// rtl/byang_prereduce.sv - reduces a raw 256-bit operand modulo the secp256k1 prime, one limb per cycle
module byang_prereduce #(
  parameter int LIMB_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  logic [255:0] a_in,
  output logic         valid_out,
  input  logic         ready_out,
  output logic [255:0] a_out,
  output logic         zero_out
);

  localparam int NLIMB = 256 / LIMB_W;
  localparam int CNT_W = $clog2(NLIMB);
  localparam int SH    = $clog2(LIMB_W);
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       a_q, a_d;
  logic [255:0]       d_q, d_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               za_q, za_d;
  logic               zd_q, zd_d;

  // Current limb slice and its subtract-with-borrow result.
  logic [7:0]         limb_lsb;
  logic [LIMB_W-1:0]  a_limb;
  logic [LIMB_W-1:0]  p_limb;
  logic [LIMB_W:0]    diff;

  assign limb_lsb = 8'(cnt_q) << SH;
  assign a_limb   = a_q[limb_lsb +: LIMB_W];
  assign p_limb   = P[limb_lsb +: LIMB_W];
  assign diff     = {1'b0, a_limb} - {1'b0, p_limb} - {{LIMB_W{1'b0}}, borrow_q};

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      za_q     <= 1'b0;
      zd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      za_q     <= za_d;
      zd_q     <= zd_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, one limb per SUB cycle, wait in HOLD.
  // borrow_q is left untouched in HOLD, so it doubles as the final borrow of A - p.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    za_d     = za_q;
    zd_d     = zd_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d      = a_in;
          borrow_d = 1'b0;
          cnt_d    = '0;
          za_d     = 1'b0;
          zd_d     = 1'b0;
          state_d  = SUB;
        end
      end
      SUB: begin
        d_d[limb_lsb +: LIMB_W] = diff[LIMB_W-1:0];
        borrow_d = diff[LIMB_W];
        za_d     = za_q | (|a_limb);
        zd_d     = zd_q | (|diff[LIMB_W-1:0]);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: a borrow means A < p, so A is already reduced; otherwise A - p is the answer.
  always_comb begin
    ready_in  = (state_q == IDLE);
    valid_out = (state_q == HOLD);
    a_out     = borrow_q ? a_q : d_q;
    zero_out  = (state_q == HOLD) && (borrow_q ? ~za_q : ~zd_q);
  end

endmodule

// File: tb/tb_byang_prereduce.sv
// tb/tb_byang_prereduce.sv - self-checking bench for byang_prereduce at LIMB_W 32 and 64
module tb_byang_prereduce;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] ONES = {256{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in  [2];
  logic         ready_in  [2];
  logic         valid_out [2];
  logic         ready_out [2];
  logic         zero_out  [2];
  logic [255:0] a_in      [2];
  logic [255:0] a_out     [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byang_prereduce #(.LIMB_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in[0]), .ready_in(ready_in[0]),
    .a_in(a_in[0]), .valid_out(valid_out[0]), .ready_out(ready_out[0]),
    .a_out(a_out[0]), .zero_out(zero_out[0])
  );

  byang_prereduce #(.LIMB_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in[1]), .ready_in(ready_in[1]),
    .a_in(a_in[1]), .valid_out(valid_out[1]), .ready_out(ready_out[1]),
    .a_out(a_out[1]), .zero_out(zero_out[1])
  );

  typedef struct {
    logic [255:0] a;
    logic [255:0] exp_a;
    logic         exp_z;
  } vec_t;

  function automatic logic [255:0] ref_mod(input logic [255:0] a);
    return (a >= P) ? a - P : a;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd_operand();
    logic [255:0] r;
    case ($urandom_range(0, 4))
      0: r = rnd256();
      1: r = P + 256'($urandom_range(0, 2000));
      2: r = P - 256'($urandom_range(0, 2000));
      3: r = ONES - 256'($urandom_range(0, 2000));
      default: r = 256'($urandom_range(0, 2000));
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; offers one operand and returns at the negedge where valid_out is seen.
  task automatic run_one(input int k, input logic [255:0] a,
                         output logic [255:0] res, output logic z, output int lat);
    valid_in[k] = 1'b1;
    a_in[k]     = a;
    check("ready_in_before_accept", 256'(ready_in[k]), 256'd1);
    @(posedge clk);
    @(negedge clk);
    valid_in[k] = 1'b0;
    a_in[k]     = rnd256();
    lat = 0;
    while (!valid_out[k] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = a_out[k];
    z   = zero_out[k];
  endtask

  initial begin
    vec_t         tbl [8];
    logic [255:0] res, hold_val;
    logic         z;
    int           lat, seen;

    tbl[0] = '{256'd5,        256'd5,            1'b0};
    tbl[1] = '{P,             256'd0,            1'b1};
    tbl[2] = '{P + 256'd1,    256'd1,            1'b0};
    tbl[3] = '{256'd0,        256'd0,            1'b1};
    tbl[4] = '{ONES,          256'h1000003D0,    1'b0};
    tbl[5] = '{P - 256'd1,    P - 256'd1,        1'b0};
    tbl[6] = '{256'd1 << 255, 256'd1 << 255,     1'b0};
    tbl[7] = '{P + 256'h1234, 256'h1234,         1'b0};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_in[k]  = 1'b0;
      ready_out[k] = 1'b0;
      a_in[k]      = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_ready_in",  256'(ready_in[k]),  256'd1);
      check("reset_valid_out", 256'(valid_out[k]), 256'd0);
      check("reset_zero_out",  256'(zero_out[k]),  256'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on both widths, ready_out held high.
    for (int k = 0; k < 2; k++) begin
      ready_out[k] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        run_one(k, tbl[i].a, res, z, lat);
        check("vec_latency",  256'(lat), 256'(k == 0 ? 8 : 4));
        check("vec_a_out",    res,       tbl[i].exp_a);
        check("vec_zero_out", 256'(z),   256'(tbl[i].exp_z));
        @(posedge clk);
        @(negedge clk);
        check("vec_ready_after_hs", 256'(ready_in[k]),  256'd1);
        check("vec_valid_after_hs", 256'(valid_out[k]), 256'd0);
      end
      ready_out[k] = 1'b0;
    end

    // Backpressure: HOLD for 5 cycles while a_in and valid_in toggle.
    ready_out[0] = 1'b0;
    run_one(0, P + 256'd42, res, z, lat);
    check("bp_a_out", res, 256'd42);
    hold_val = res;
    for (int i = 0; i < 5; i++) begin
      a_in[0]     = rnd256();
      valid_in[0] = ~valid_in[0];
      @(posedge clk);
      @(negedge clk);
      check("bp_a_out_stable", a_out[0],             hold_val);
      check("bp_valid_out",    256'(valid_out[0]),   256'd1);
      check("bp_ready_in_low", 256'(ready_in[0]),    256'd0);
    end
    valid_in[0]  = 1'b0;
    ready_out[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid_out", 256'(valid_out[0]), 256'd0);
    check("bp_release_ready_in",  256'(ready_in[0]),  256'd1);

    // Reset in the middle of SUB, at limb 3.
    valid_in[0] = 1'b1;
    a_in[0]     = 256'd99;
    @(posedge clk);
    @(negedge clk);
    valid_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready_in",  256'(ready_in[0]),  256'd1);
    check("midreset_valid_out", 256'(valid_out[0]), 256'd0);
    check("midreset_zero_out",  256'(zero_out[0]),  256'd0);
    check("midreset_a_out",     a_out[0],           256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_out[0]) seen = 1;
    end
    check("midreset_no_valid_out", 256'(seen), 256'd0);

    // Accept on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_one(0, 256'd7, res, z, lat);
    check("post_reset_latency", 256'(lat), 256'd8);
    check("post_reset_a_out",   res,       256'd7);
    @(posedge clk);
    @(negedge clk);
    ready_out[0] = 1'b0;

    // Random traffic with random gaps against the a mod p reference.
    for (int k = 0; k < 2; k++) begin
      logic [255:0] q[$];
      logic [255:0] e;
      int acc = 0;
      int got = 0;
      int cyc = 0;
      while ((acc < 200 || got < acc) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        valid_in[k]  = (acc < 200) && ($urandom_range(0, 3) != 0);
        a_in[k]      = rnd_operand();
        ready_out[k] = ($urandom_range(0, 2) != 0);
        if (valid_in[k] && ready_in[k]) begin
          q.push_back(a_in[k]);
          acc++;
        end
        if (valid_out[k] && ready_out[k]) begin
          if (q.size() == 0) begin
            check("rand_unexpected_output", 256'd1, 256'd0);
          end else begin
            e = ref_mod(q.pop_front());
            check("rand_a_out",    a_out[k],           e);
            check("rand_zero_out", 256'(zero_out[k]),  256'(e == 256'd0));
            got++;
          end
        end
      end
      @(negedge clk);
      valid_in[k]  = 1'b0;
      ready_out[k] = 1'b1;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (valid_out[k]) seen = 1;
      end
      check("rand_accepted",     256'(acc),      256'd200);
      check("rand_received",     256'(got),      256'd200);
      check("rand_queue_empty",  256'(q.size()), 256'd0);
      check("rand_no_duplicate", 256'(seen),     256'd0);
      ready_out[k] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
